// File: rtl/mips_defs.sv
// Shared constants for the MIPS pipeline: reset PC, bubble word and fetch FSM encodings.
package mips_defs;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, insert a bubble, or hold.
module if_id_reg
    import mips_defs::*;
#(
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pcplus,
    input  logic        load_adel,
    output logic [31:0] instr,
    output logic [31:0] pcplus,
    output logic        valid,
    output logic        adel
);

    // A bubble leaves pcplus untouched; only instr/valid/adel mark it as empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr  <= NOP_INSTR;
            pcplus <= 32'd0;
            valid  <= 1'b0;
            adel   <= 1'b0;
        end else if (bubble) begin
            instr  <= NOP_INSTR;
            valid  <= 1'b0;
            adel   <= 1'b0;
        end else if (load) begin
            instr  <= load_instr;
            pcplus <= load_pcplus;
            valid  <= 1'b1;
            adel   <= load_adel;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, req/ack instruction fetch FSM and IF/ID register.
// Optional misaligned-PC check is built when FETCH_ALIGN_CHECK_EN is defined.
module fetch_stage
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc_address,
    input  logic        stallD,
    input  logic        flushD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pcF,
    output logic [31:0] pcplusF,
    output logic [31:0] instrD,
    output logic [31:0] pcplusD,
    output logic        validD,
    output logic        adelD
);

    logic [1:0]  state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] redir, redir_nxt;
    logic [31:0] hold, hold_nxt;
    logic        ifid_load, ifid_bubble, ifid_adel;
    logic [31:0] ifid_instr;
    logic        misalign;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign = (pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign pcF       = pc;
    assign pcplusF   = pc + 32'd4;
    assign imem_addr = pc;
    assign imem_req  = ((state == S_REQ) && !misalign) || (state == S_DRAIN);

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        redir_nxt   = redir;
        hold_nxt    = hold;
        ifid_load   = 1'b0;
        ifid_bubble = flushD;
        ifid_instr  = hold;
        ifid_adel   = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (misalign) begin
                    // No request is issued; the error rides down the pipe as a valid NOP.
                    if (flushD) begin
                        pc_nxt = npc_address;
                    end else if (!stallD) begin
                        ifid_load  = 1'b1;
                        ifid_instr = NOP_INSTR;
                        ifid_adel  = 1'b1;
                        pc_nxt     = npc_address;
                    end
                end else if (flushD) begin
                    if (imem_ack) begin
                        pc_nxt = npc_address;
                    end else begin
                        redir_nxt = npc_address;
                        state_nxt = S_DRAIN;
                    end
                end else if (imem_ack && !stallD) begin
                    ifid_load  = 1'b1;
                    ifid_instr = imem_rdata;
                    pc_nxt     = npc_address;
                end else if (imem_ack) begin
                    hold_nxt  = imem_rdata;
                    state_nxt = S_HOLD;
                end else begin
                    ifid_bubble = !stallD;
                end
            end
            S_HOLD: begin
                if (flushD) begin
                    hold_nxt  = 32'd0;
                    pc_nxt    = npc_address;
                    state_nxt = S_REQ;
                end else if (!stallD) begin
                    ifid_load = 1'b1;
                    pc_nxt    = npc_address;
                    state_nxt = S_REQ;
                end
            end
            default: begin
                // S_DRAIN: finish the abandoned request, then jump to the latest redirect.
                ifid_bubble = 1'b1;
                if (imem_ack) begin
                    pc_nxt    = flushD ? npc_address : redir;
                    state_nxt = S_REQ;
                end else if (flushD) begin
                    redir_nxt = npc_address;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            redir <= 32'd0;
            hold  <= 32'd0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            redir <= redir_nxt;
            hold  <= hold_nxt;
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ifid_load),
        .bubble     (ifid_bubble),
        .load_instr (ifid_instr),
        .load_pcplus(pcplusF),
        .load_adel  (ifid_adel),
        .instr      (instrD),
        .pcplus     (pcplusD),
        .valid      (validD),
        .adel       (adelD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected IF/ID contents.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] npc_address;
    logic        stallD;
    logic        flushD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pcF;
    logic [31:0] pcplusF;
    logic [31:0] instrD;
    logic [31:0] pcplusD;
    logic        validD;
    logic        adelD;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus;
        logic        adel;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   tests = 0;
    int   fails = 0;

    fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .npc_address(npc_address),
        .stallD     (stallD),
        .flushD     (flushD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pcF        (pcF),
        .pcplusF    (pcplusF),
        .instrD     (instrD),
        .pcplusD    (pcplusD),
        .validD     (validD),
        .adelD      (adelD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_fetch(input logic [31:0] a);
        sb.push_back('{instr: mem_word(a), pcplus: a + 32'd4, adel: 1'b0});
    endtask

    // Check the request side, drive one cycle of inputs, then check IF/ID after the edge.
    task automatic cyc(input logic ack, input logic stall, input logic flush,
                       input logic [31:0] npc, input logic ereq,
                       input logic [31:0] eaddr, input logic evalid);
        chk("imem_req", {31'd0, imem_req}, {31'd0, ereq});
        if (ereq) begin
            chk("imem_addr", imem_addr, eaddr);
            chk("pcplusF", pcplusF, eaddr + 32'd4);
        end
        imem_ack    = ack;
        stallD      = stall;
        flushD      = flush;
        npc_address = npc;
        imem_rdata  = ack ? mem_word(eaddr) : 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        if (sb.size() > 0) last = sb.pop_front();
        chk("validD", {31'd0, validD}, {31'd0, evalid});
        if (evalid) begin
            chk("instrD", instrD, last.instr);
            chk("pcplusD", pcplusD, last.pcplus);
            chk("adelD", {31'd0, adelD}, {31'd0, last.adel});
        end else begin
            chk("instrD_bubble", instrD, 32'h0000_0000);
            chk("adelD_bubble", {31'd0, adelD}, 32'd0);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_pcF", pcF, 32'h0000_3000);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_instrD", instrD, 32'h0000_0000);
        chk("rst_pcplusD", pcplusD, 32'd0);
        chk("rst_validD", {31'd0, validD}, 32'd0);
        chk("rst_adelD", {31'd0, adelD}, 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        npc_address = 32'd0;
        stallD      = 1'b0;
        flushD      = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        last        = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;

        // idle cycle after reset
        cyc(0, 0, 0, 32'h0, 0, 32'h0, 0);
        // zero-wait fetches
        push_fetch(32'h3000);
        cyc(1, 0, 0, 32'h3004, 1, 32'h3000, 1);
        push_fetch(32'h3004);
        cyc(1, 0, 0, 32'h3008, 1, 32'h3004, 1);
        // ack under stall, hold three cycles, release
        cyc(1, 1, 0, 32'h300C, 1, 32'h3008, 1);
        cyc(0, 1, 0, 32'h300C, 0, 32'h0, 1);
        cyc(0, 1, 0, 32'h300C, 0, 32'h0, 1);
        push_fetch(32'h3008);
        cyc(0, 0, 0, 32'h3040, 0, 32'h0, 1);
        // two-cycle ack latency
        cyc(0, 0, 0, 32'h0, 1, 32'h3040, 0);
        cyc(0, 0, 0, 32'h0, 1, 32'h3040, 0);
        push_fetch(32'h3040);
        cyc(1, 0, 0, 32'h3044, 1, 32'h3040, 1);
        // flush while pending, second flush in drain wins
        cyc(0, 0, 1, 32'h4100, 1, 32'h3044, 0);
        cyc(0, 0, 1, 32'h4180, 1, 32'h3044, 0);
        cyc(1, 0, 0, 32'h0, 1, 32'h3044, 0);
        push_fetch(32'h4180);
        cyc(1, 0, 0, 32'h4184, 1, 32'h4180, 1);
        // flush and stall together in hold
        cyc(1, 1, 0, 32'h0, 1, 32'h4184, 1);
        cyc(0, 1, 1, 32'h5000, 0, 32'h0, 0);
        cyc(0, 0, 0, 32'h0, 1, 32'h5000, 0);
        push_fetch(32'h5000);
        cyc(1, 0, 0, 32'h5004, 1, 32'h5000, 1);
        // flush with ack in request state, then PC wrap
        cyc(1, 0, 1, 32'h6000, 1, 32'h5004, 0);
        cyc(1, 0, 1, 32'hFFFF_FFFC, 1, 32'h6000, 0);
        push_fetch(32'hFFFF_FFFC);
        cyc(1, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 1);
        // leave a request outstanding with IF/ID valid, then reset mid-transaction
        cyc(0, 1, 0, 32'h0, 1, 32'h0, 1);
        rst_n = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        rst_n    = 1'b1;
        imem_ack = 1'b0;
        stallD   = 1'b0;
        cyc(0, 0, 0, 32'h0, 0, 32'h0, 0);
        push_fetch(32'h3000);
        cyc(1, 0, 0, 32'h3004, 1, 32'h3000, 1);
`ifdef FETCH_ALIGN_CHECK_EN
        cyc(1, 0, 1, 32'h3002, 1, 32'h3004, 0);
        sb.push_back('{instr: 32'h0000_0000, pcplus: 32'h3006, adel: 1'b1});
        cyc(0, 0, 0, 32'h3008, 0, 32'h0, 1);
        cyc(1, 0, 0, 32'h300C, 1, 32'h3008, 0);
`endif
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
